// File: rtl/wb_config_loader.sv
// rtl/wb_config_loader.sv - Wishbone slave turning DATA writes into per-column serial config streams
// Optional build macro CFG_READBACK_EN adds cfg_tail_i capture and DATA readback.
module wb_config_loader #(
    parameter int          MX        = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_dat_i,
    input  logic [31:0]   wbs_adr_i,
`ifdef CFG_READBACK_EN
    input  logic [MX-1:0] cfg_tail_i,
`endif
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic [MX-1:0] cfg_data_o,
    output logic [MX-1:0] cfg_en_o,
    output logic          fabric_rst_o
);

    typedef enum logic [1:0] {IDLE, SHIFT, ACK} state_t;

    state_t           state;
    logic [7:0]       shreg  [MX];
    logic [3:0]       rem    [MX];
    logic [7:0]       bitcnt [MX];
    logic [3:0]       eff    [MX];
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] cyc_next;
    logic [31:0]      rd_data;
    logic [3:0]       offset;
    logic             req;
    logic             any_load;
    logic             any_rem;
`ifdef CFG_READBACK_EN
    logic [7:0]       rb     [MX];
`endif

    assign offset   = wbs_adr_i[3:0];
    assign req      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign cyc_next = (&cyc_cnt) ? cyc_cnt : cyc_cnt + 1'b1;

    always_comb begin
        any_load = 1'b0;
        any_rem  = 1'b0;
        for (int j = 0; j < MX; j++) begin
            eff[j] = (bitcnt[j] > 8'd8) ? 4'd8 : bitcnt[j][3:0];
            if (wbs_sel_i[j] && eff[j] != 4'd0)
                any_load = 1'b1;
            if (rem[j] != 4'd0)
                any_rem = 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        case (offset)
            4'd0: rd_data = {31'b0, fabric_rst_o};
            4'd1: for (int j = 0; j < MX; j++) rd_data[8*j +: 8] = bitcnt[j];
`ifdef CFG_READBACK_EN
            4'd2: for (int j = 0; j < MX; j++) rd_data[8*j +: 8] = rb[j];
`endif
            4'd3: rd_data = {(state != IDLE), 15'b0, 16'(cyc_cnt)};
            default: rd_data = '0;
        endcase
    end

    // The first bit of every loaded lane is presented straight off the accept
    // edge, so cfg_en_o covers cycles 1..N and the ack lands in cycle N+1.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state        <= IDLE;
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            cfg_en_o     <= '0;
            cfg_data_o   <= '0;
            fabric_rst_o <= 1'b1;
            cyc_cnt      <= '0;
            for (int j = 0; j < MX; j++) begin
                shreg[j]  <= '0;
                rem[j]    <= '0;
                bitcnt[j] <= 8'd8;
`ifdef CFG_READBACK_EN
                rb[j]     <= '0;
`endif
            end
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
`ifdef CFG_READBACK_EN
            for (int j = 0; j < MX; j++)
                if (cfg_en_o[j])
                    rb[j] <= {cfg_tail_i[j], rb[j][7:1]};
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        if (wbs_we_i && offset == 4'd2) begin
                            for (int j = 0; j < MX; j++) begin
                                if (wbs_sel_i[j] && eff[j] != 4'd0) begin
                                    cfg_en_o[j]   <= 1'b1;
                                    cfg_data_o[j] <= wbs_dat_i[8*j];
                                    shreg[j]      <= {1'b0, wbs_dat_i[8*j+1 +: 7]};
                                    rem[j]        <= eff[j] - 4'd1;
                                end else begin
                                    cfg_en_o[j] <= 1'b0;
                                    rem[j]      <= 4'd0;
                                end
                            end
                            if (any_load) begin
                                state   <= SHIFT;
                                cyc_cnt <= cyc_next;
                            end else begin
                                state     <= ACK;
                                wbs_ack_o <= 1'b1;
                            end
                        end else begin
                            if (wbs_we_i) begin
                                if (offset == 4'd0 && wbs_sel_i[0]) begin
                                    fabric_rst_o <= wbs_dat_i[0];
                                    if (wbs_dat_i[1])
                                        cyc_cnt <= '0;
                                end
                                if (offset == 4'd1)
                                    for (int j = 0; j < MX; j++)
                                        if (wbs_sel_i[j])
                                            bitcnt[j] <= wbs_dat_i[8*j +: 8];
                            end else begin
                                wbs_dat_o <= rd_data;
                            end
                            state     <= ACK;
                            wbs_ack_o <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    for (int j = 0; j < MX; j++) begin
                        if (rem[j] != 4'd0) begin
                            cfg_en_o[j]   <= 1'b1;
                            cfg_data_o[j] <= shreg[j][0];
                            shreg[j]      <= {1'b0, shreg[j][7:1]};
                            rem[j]        <= rem[j] - 4'd1;
                        end else begin
                            cfg_en_o[j] <= 1'b0;
                        end
                    end
                    if (any_rem) begin
                        cyc_cnt <= cyc_next;
                    end else begin
                        state     <= ACK;
                        wbs_ack_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_config_loader.sv
// tb/tb_wb_config_loader.sv - scoreboard bench for wb_config_loader with randomized bus traffic
module tb_wb_config_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc_i = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat = '0, adr = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [3:0]  cdata, cen;
    logic        frst;
`ifdef CFG_READBACK_EN
    logic [3:0]  tail = 4'h0;
`endif

    wb_config_loader dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc_i), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr),
`ifdef CFG_READBACK_EN
        .cfg_tail_i(tail),
`endif
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .cfg_data_o(cdata), .cfg_en_o(cen), .fabric_rst_o(frst)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [31:0] dat; logic frst; } ack_t;
    typedef struct { int cyc; logic [3:0] en; logic [3:0] d; } en_t;

    ack_t exp_ack[$];
    en_t  exp_en[$];
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;

    logic [7:0] m_bc [4];
    logic       m_frst;
    int         m_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, expv);
        end
    endfunction

    function automatic void model_reset();
        for (int j = 0; j < 4; j++) m_bc[j] = 8'd8;
        m_frst = 1'b1;
        m_cyc  = 0;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_en.size() > 0 && exp_en[0].cyc < cyc) begin
                void'(exp_en.pop_front());
                chk("en_missed", 32'(cyc), 32'(cyc - 1));
            end
            while (exp_ack.size() > 0 && exp_ack[0].cyc < cyc) begin
                void'(exp_ack.pop_front());
                chk("ack_missed", 32'(cyc), 32'(cyc - 1));
            end
            if (exp_en.size() > 0 && exp_en[0].cyc == cyc) begin
                en_t e;
                e = exp_en.pop_front();
                chk("cfg_en", 32'(cen), 32'(e.en));
                chk("cfg_data", 32'(cdata & e.en), 32'(e.d));
            end else begin
                chk("cfg_en_idle", 32'(cen), 32'h0);
            end
            if (exp_ack.size() > 0 && exp_ack[0].cyc == cyc) begin
                ack_t a;
                a = exp_ack.pop_front();
                chk("ack", 32'(ack), 32'h1);
                chk("rdata", rdat, a.dat);
                chk("fabric_rst", 32'(frst), 32'(a.frst));
            end else begin
                chk("ack_idle", 32'(ack), 32'h0);
                chk("rdata_idle", rdat, 32'h0);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
        int acc, n;
        int c [4];
        logic [31:0] rd;
        @(negedge clk);
        acc = cyc;
        adr = a; we = w; sel = s; dat = d; stb = 1'b1; cyc_i = 1'b1;
        if (a[31:4] == BASE[31:4]) begin
            if (w && a[3:0] == 4'd2) begin
                n = 0;
                for (int j = 0; j < 4; j++) begin
                    c[j] = s[j] ? ((m_bc[j] > 8'd8) ? 8 : int'(m_bc[j])) : 0;
                    if (c[j] > n) n = c[j];
                end
                for (int k = 1; k <= n; k++) begin
                    en_t e;
                    e.cyc = acc + k; e.en = '0; e.d = '0;
                    for (int j = 0; j < 4; j++)
                        if (c[j] >= k) begin
                            e.en[j] = 1'b1;
                            e.d[j]  = d[8*j + k - 1];
                        end
                    exp_en.push_back(e);
                end
                m_cyc = (m_cyc + n > 65535) ? 65535 : m_cyc + n;
                exp_ack.push_back('{acc + n + 1, 32'h0, m_frst});
            end else begin
                case (a[3:0])
                    4'd0:    rd = {31'b0, m_frst};
                    4'd1:    rd = {m_bc[3], m_bc[2], m_bc[1], m_bc[0]};
                    4'd3:    rd = 32'(m_cyc);
                    default: rd = 32'h0;
                endcase
                if (w && a[3:0] == 4'd0 && s[0]) begin
                    m_frst = d[0];
                    if (d[1]) m_cyc = 0;
                end
                if (w && a[3:0] == 4'd1)
                    for (int j = 0; j < 4; j++)
                        if (s[j]) m_bc[j] = d[8*j +: 8];
                exp_ack.push_back('{acc + 1, w ? 32'h0 : rd, m_frst});
            end
        end
        @(posedge clk);
    endtask

    task automatic idle_bus();
        stb = 1'b0; cyc_i = 1'b0; we = 1'b0; sel = 4'h0; dat = '0; adr = '0;
    endtask

    task automatic access(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d, input bit drop);
        bit got;
        issue(a, w, s, d);
        if (drop) begin
            #1 idle_bus();
        end
        if (a[31:4] != BASE[31:4]) begin
            repeat (4) @(negedge clk);
            idle_bus();
        end else begin
            got = 1'b0;
            for (int t = 0; t < 30 && !got; t++) begin
                @(negedge clk);
                if (ack) got = 1'b1;
            end
            if (!got) chk("ack_timeout", 32'h0, 32'h1);
            idle_bus();
        end
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0] off_tab [8];
        off_tab = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd5, 4'd15};
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_fabric_rst", 32'(frst), 32'h1);
        chk("reset_cfg_en", 32'(cen), 32'h0);
        chk("reset_cfg_data", 32'(cdata), 32'h0);

        access(BASE | 32'd3, 1'b0, 4'hF, 32'h0, 1'b0);
        access(BASE | 32'd0, 1'b1, 4'hF, 32'h0, 1'b0);
        access(BASE | 32'd1, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0);
        access(BASE | 32'd2, 1'b1, 4'hF, 32'hA53C_0F81, 1'b0);
        access(BASE | 32'd3, 1'b0, 4'hF, 32'h0, 1'b0);
        access(BASE | 32'd1, 1'b1, 4'hF, 32'h0303_0303, 1'b0);
        access(BASE | 32'd2, 1'b1, 4'h1, 32'h0000_0005, 1'b0);
        access(BASE | 32'd1, 1'b1, 4'hF, 32'h0205_0008, 1'b0);
        access(BASE | 32'd2, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0);
        access(BASE | 32'd2, 1'b1, 4'hF, 32'h5A5A_C3C3, 1'b1);
        access(BASE | 32'd2, 1'b1, 4'h0, 32'hFFFF_FFFF, 1'b0);
        access(BASE | 32'd1, 1'b0, 4'hF, 32'h0, 1'b0);
        access(BASE | 32'd3, 1'b0, 4'hF, 32'h0, 1'b0);
        access(32'h3000_0012, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0);
        access(32'h4000_0002, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0);

        for (int i = 0; i < 60; i++) begin
            a = BASE | 32'(off_tab[$urandom_range(0, 7)]);
            d = $urandom;
            if (a[3:0] == 4'd1 && $urandom_range(0, 1) == 0)
                for (int j = 0; j < 4; j++) d[8*j +: 8] = 8'($urandom_range(0, 10));
            if (a[3:0] == 4'd0) d[1] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) a = a + 32'h10;
            access(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), d, $urandom_range(0, 3) == 0);
        end

        access(BASE | 32'd1, 1'b1, 4'hF, 32'h0808_0808, 1'b0);
        issue(BASE | 32'd2, 1'b1, 4'hF, 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        exp_en.delete();
        exp_ack.delete();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cfg_en", 32'(cen), 32'h0);
        chk("rst_mid_ack", 32'(ack), 32'h0);
        chk("rst_mid_fabric_rst", 32'(frst), 32'h1);
        idle_bus();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        access(BASE | 32'd3, 1'b0, 4'hF, 32'h0, 1'b0);
        access(BASE | 32'd0, 1'b0, 4'hF, 32'h0, 1'b0);
        repeat (3) @(negedge clk);

        chk("ack_queue_empty", 32'(exp_ack.size()), 32'h0);
        chk("en_queue_empty", 32'(exp_en.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
